// File: rtl/utm_tape_engine_if.sv
// Link between the tape engine and the combinational next-state block.
// master = tape engine, slave = next-state logic.
interface utm_tape_engine_if #(
  parameter int SYM_W   = 3,
  parameter int STATE_W = 5
);

  logic [STATE_W-1:0] ns_state;
  logic [SYM_W-1:0]   ns_sym;
  logic [STATE_W-1:0] ns_next_state;
  logic [SYM_W-1:0]   ns_write_sym;
  logic               ns_move_right;
  logic               ns_halt;

  modport master (
    output ns_state,
    output ns_sym,
    input  ns_next_state,
    input  ns_write_sym,
    input  ns_move_right,
    input  ns_halt
  );

  modport slave (
    input  ns_state,
    input  ns_sym,
    output ns_next_state,
    output ns_write_sym,
    output ns_move_right,
    output ns_halt
  );

endinterface

// File: rtl/utm_tape_engine.sv
// Tape, head, state and step counter of the UTM; commits one machine step
// per enabled clock using the unregistered answer of the next-state block.
module utm_tape_engine #(
  parameter int TAPE_LEN   = 16,
  parameter int SYM_W      = 3,
  parameter int STATE_W    = 5,
  parameter int HEAD_START = 8,
  parameter int MAX_STEPS  = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load_en,
  input  logic [SYM_W-1:0]            load_sym,
  input  logic                        start,
  input  logic                        step_en,
  utm_tape_engine_if.master           ns,
  output logic [$clog2(TAPE_LEN)-1:0] head,
  output logic                        busy,
  output logic                        halted,
  output logic                        timeout,
  output logic [7:0]                  step_count
);

  localparam int HEAD_W = $clog2(TAPE_LEN);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  localparam logic [HEAD_W-1:0] HEAD_ONE  = HEAD_W'(1);
  localparam logic [HEAD_W-1:0] HEAD_INIT = HEAD_W'(HEAD_START % TAPE_LEN);

  logic [1:0]         fsm;
  logic [1:0]         fsm_next;
  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_next;
  logic [HEAD_W-1:0]  head_next;
  logic [7:0]         step_next;
  logic [7:0]         step_sat;
  logic               timeout_next;
  logic               tape_we;
  logic [SYM_W-1:0]   tape_wdata;
  logic [SYM_W-1:0]   tape [TAPE_LEN];

  assign ns.ns_state = state_q;
  assign ns.ns_sym   = tape[head];

  // Counter sticks at 255 so a large MAX_STEPS can never make it wrap.
  assign step_sat = (step_count == 8'hFF) ? 8'hFF : step_count + 8'd1;

  always_comb begin
    fsm_next     = fsm;
    head_next    = head;
    state_next   = state_q;
    step_next    = step_count;
    timeout_next = timeout;
    tape_we      = 1'b0;
    tape_wdata   = load_sym;

    case (fsm)
      IDLE: begin
        if (load_en) begin
          tape_we    = 1'b1;
          tape_wdata = load_sym;
          head_next  = head + HEAD_ONE;
        end else if (start) begin
          fsm_next     = RUN;
          head_next    = HEAD_INIT;
          state_next   = '0;
          step_next    = '0;
          timeout_next = 1'b0;
        end
      end

      RUN: begin
        if (step_en) begin
          if (ns.ns_halt) begin
            fsm_next = HALT;
          end else begin
            tape_we    = 1'b1;
            tape_wdata = ns.ns_write_sym;
            state_next = ns.ns_next_state;
            head_next  = ns.ns_move_right ? head + HEAD_ONE : head - HEAD_ONE;
            step_next  = step_sat;
            if (32'(step_sat) == MAX_STEPS) begin
              fsm_next     = HALT;
              timeout_next = 1'b1;
            end
          end
        end
      end

      HALT: begin
        if (start) begin
          fsm_next     = IDLE;
          timeout_next = 1'b0;
        end
      end

      default: fsm_next = IDLE;
    endcase
  end

  // Status flags are decoded from the next FSM value so they land as flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm        <= IDLE;
      head       <= '0;
      state_q    <= '0;
      step_count <= '0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      for (int i = 0; i < TAPE_LEN; i++) begin
        tape[i] <= '0;
      end
    end else begin
      fsm        <= fsm_next;
      head       <= head_next;
      state_q    <= state_next;
      step_count <= step_next;
      timeout    <= timeout_next;
      busy       <= (fsm_next == RUN);
      halted     <= (fsm_next == HALT);
      if (tape_we) begin
        tape[head] <= tape_wdata;
      end
    end
  end

endmodule
